// File: rtl/flush_ctrl_if.sv
// flush_ctrl_if: groups the recovery-sequencer signals between the branch
// predictor / speculative units / memory (master side) and flush_ctrl (slave).
//   rdy_in          global ready, low freezes the sequencer
//   predict_fail    misprediction detected this cycle
//   fail_addr       correct-path PC
//   unit_flush_ack  per-unit "flush complete" level
//   mem_busy        non-abortable memory transaction in flight
//   flush_out       one-cycle flush pulse to all units
//   stall_fetch     fetch must not advance
//   redirect_valid  one-cycle PC load strobe
//   redirect_addr   recovery PC
//   busy            sequencer not idle
//   timeout_err     sticky WAIT timeout flag
//   flush_count     saturating count of accepted mispredictions
interface flush_ctrl_if #(
    parameter int NUM_UNITS = 4,
    parameter int CNT_W     = 16
);
    logic                 rdy_in;
    logic                 predict_fail;
    logic [31:0]          fail_addr;
    logic [NUM_UNITS-1:0] unit_flush_ack;
    logic                 mem_busy;
    logic                 flush_out;
    logic                 stall_fetch;
    logic                 redirect_valid;
    logic [31:0]          redirect_addr;
    logic                 busy;
    logic                 timeout_err;
    logic [CNT_W-1:0]     flush_count;

    modport master (
        output rdy_in, predict_fail, fail_addr, unit_flush_ack, mem_busy,
        input  flush_out, stall_fetch, redirect_valid, redirect_addr,
               busy, timeout_err, flush_count
    );

    modport slave (
        input  rdy_in, predict_fail, fail_addr, unit_flush_ack, mem_busy,
        output flush_out, stall_fetch, redirect_valid, redirect_addr,
               busy, timeout_err, flush_count
    );
endinterface

// File: rtl/flush_ctrl.sv
// flush_ctrl: pipeline recovery sequencer after a branch misprediction.
// Accepts a misprediction in IDLE, broadcasts a one-cycle flush, waits for
// every unit to acknowledge and memory to go idle (or a timeout), then issues
// a single redirect with the recovery PC.
//   clk_in  clock, all state updates on posedge
//   rst_in  asynchronous active-high reset
//   bus     flush_ctrl_if.slave, see the interface file for the signal list
module flush_ctrl #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    flush_ctrl_if.slave  bus
);
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, WAIT, REDIRECT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [NUM_UNITS-1:0] ack_seen_q, ack_seen_d;
    logic [NUM_UNITS-1:0] ack_now;
    logic [WC_W-1:0]      wait_q, wait_d;
    logic                 terr_q, terr_d;

    // Acks are sticky within a WAIT episode; a unit counts as done if it was
    // seen earlier or is acknowledging right now.
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_ack
        assign ack_now[gi] = ack_seen_q[gi] | bus.unit_flush_ack[gi];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            ack_seen_q <= '0;
            wait_q     <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            ack_seen_q <= ack_seen_d;
            wait_q     <= wait_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        ack_seen_d = ack_seen_q;
        wait_d     = wait_q;
        terr_d     = terr_q;
        // With rdy_in low every register simply holds.
        if (bus.rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (bus.predict_fail) begin
                        addr_d  = {bus.fail_addr[31:1], 1'b0};
                        if (count_q != '1) begin
                            count_d = count_q + CNT_W'(1);
                        end
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    ack_seen_d = '0;
                    wait_d     = '0;
                    state_d    = WAIT;
                end
                WAIT: begin
                    ack_seen_d = ack_now;
                    wait_d     = wait_q + WC_W'(1);
                    if ((&ack_now) && !bus.mem_busy) begin
                        state_d = REDIRECT;
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = REDIRECT;
                        terr_d  = 1'b1;
                    end
                end
                REDIRECT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs decode the state register directly. The two pulses are masked by
    // rdy_in so a pulse held off by a stall reappears once rdy_in returns,
    // because the state stays frozen on it.
    assign bus.flush_out      = (state_q == FLUSH) && bus.rdy_in;
    assign bus.redirect_valid = (state_q == REDIRECT) && bus.rdy_in;
    assign bus.stall_fetch    = (state_q != IDLE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.redirect_addr  = addr_q;
    assign bus.timeout_err    = terr_q;
    assign bus.flush_count    = count_q;
endmodule

// File: tb/tb_flush_ctrl.sv
module tb_flush_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    flush_ctrl_if #(.NUM_UNITS(4), .CNT_W(16)) bus ();

    flush_ctrl #(.NUM_UNITS(4), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        rdy;
        logic        pf;
        logic [31:0] addr;
        logic [3:0]  ack;
        logic        mb;
        logic        fl;
        logic        st;
        logic        rv;
        logic [31:0] ra;
        logic        bs;
        logic        te;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic fl, input logic st, input logic rv,
                            input logic [31:0] ra, input logic bs, input logic te,
                            input logic [15:0] cnt);
        chk({tag, ".flush_out"},      32'(bus.flush_out),      32'(fl));
        chk({tag, ".stall_fetch"},    32'(bus.stall_fetch),    32'(st));
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
        chk({tag, ".redirect_addr"},  bus.redirect_addr,       ra);
        chk({tag, ".busy"},           32'(bus.busy),           32'(bs));
        chk({tag, ".timeout_err"},    32'(bus.timeout_err),    32'(te));
        chk({tag, ".flush_count"},    32'(bus.flush_count),    32'(cnt));
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic add(input logic rdy, input logic pf, input logic [31:0] addr,
                       input logic [3:0] ack, input logic mb,
                       input logic fl, input logic st, input logic rv,
                       input logic [31:0] ra, input logic [15:0] cnt);
        vec_t v;
        v.rdy = rdy; v.pf = pf; v.addr = addr; v.ack = ack; v.mb = mb;
        v.fl = fl; v.st = st; v.rv = rv; v.ra = ra;
        v.bs = st; v.te = 1'b0; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        int first_rv;
        int rv_cnt;

        bus.rdy_in = 1'b1;
        bus.predict_fail = 1'b0;
        bus.fail_addr = '0;
        bus.unit_flush_ack = '0;
        bus.mem_busy = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        step();
        rst_in = 1'b0;

        // Each row is one cycle: inputs driven in that cycle, outputs expected in it.
        // Basic recovery
        add(1'b1, 1'b1, 32'h0000_1234, 4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h0,    16'd0);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b1, 1'b1, 1'b0, 32'h1234, 16'd1);
        add(1'b1, 1'b0, 32'h0,         4'hF, 1'b0,  1'b0, 1'b1, 1'b0, 32'h1234, 16'd1);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b1, 1'b1, 32'h1234, 16'd1);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h1234, 16'd1);
        // Back-to-back fails ignored, including one during REDIRECT
        add(1'b1, 1'b1, 32'h0000_1234, 4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h1234, 16'd1);
        add(1'b1, 1'b1, 32'h0000_2000, 4'h0, 1'b0,  1'b1, 1'b1, 1'b0, 32'h1234, 16'd2);
        add(1'b1, 1'b1, 32'h0000_2000, 4'hF, 1'b0,  1'b0, 1'b1, 1'b0, 32'h1234, 16'd2);
        add(1'b1, 1'b1, 32'h0000_3000, 4'h0, 1'b0,  1'b0, 1'b1, 1'b1, 32'h1234, 16'd2);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h1234, 16'd2);
        // Staggered acks and memory busy; odd address gets bit 0 cleared
        add(1'b1, 1'b1, 32'h0000_5677, 4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h1234, 16'd2);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b1,  1'b1, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h1, 1'b1,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b1,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h4, 1'b1,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'hA, 1'b1,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b1,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b1, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b1, 1'b1, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h5676, 16'd3);
        // predict_fail with rdy_in low is not accepted
        add(1'b0, 1'b1, 32'h0000_9999, 4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h5676, 16'd3);
        add(1'b1, 1'b0, 32'h0,         4'h0, 1'b0,  1'b0, 1'b0, 1'b0, 32'h5676, 16'd3);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.rdy_in = vecs[i].rdy;
            bus.predict_fail = vecs[i].pf;
            bus.fail_addr = vecs[i].addr;
            bus.unit_flush_ack = vecs[i].ack;
            bus.mem_busy = vecs[i].mb;
            @(negedge clk_in);
            chk_outs($sformatf("row%0d", i), vecs[i].fl, vecs[i].st, vecs[i].rv,
                     vecs[i].ra, vecs[i].bs, vecs[i].te, vecs[i].cnt);
            $display("row %0d: pf=%0b addr=%h ack=%h mb=%0b -> fl=%0b st=%0b rv=%0b ra=%h cnt=%0d",
                     i, vecs[i].pf, vecs[i].addr, vecs[i].ack, vecs[i].mb, bus.flush_out,
                     bus.stall_fetch, bus.redirect_valid, bus.redirect_addr, bus.flush_count);
            step();
        end

        // rdy_in low across the FLUSH cycle: pulse suppressed, then issued once
        bus.rdy_in = 1'b1; bus.predict_fail = 1'b1; bus.fail_addr = 32'h00AB_CDE1;
        bus.unit_flush_ack = '0; bus.mem_busy = 1'b0;
        step();
        bus.predict_fail = 1'b0; bus.rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("rdy_low.flush_out", 32'(bus.flush_out), 32'd0);
            chk("rdy_low.stall_fetch", 32'(bus.stall_fetch), 32'd1);
            chk("rdy_low.busy", 32'(bus.busy), 32'd1);
            step();
        end
        bus.rdy_in = 1'b1;
        @(negedge clk_in);
        chk_outs("rdy_back", 1'b1, 1'b1, 1'b0, 32'h00AB_CDE0, 1'b1, 1'b0, 16'd4);
        step();
        bus.unit_flush_ack = 4'hF;
        @(negedge clk_in);
        chk("rdy_wait.flush_out", 32'(bus.flush_out), 32'd0);
        chk("rdy_wait.stall_fetch", 32'(bus.stall_fetch), 32'd1);
        step();
        bus.unit_flush_ack = '0;
        @(negedge clk_in);
        chk("rdy_redir.redirect_valid", 32'(bus.redirect_valid), 32'd1);
        step();
        @(negedge clk_in);
        chk("rdy_done.stall_fetch", 32'(bus.stall_fetch), 32'd0);
        $display("rdy gating sequence done");
        step();

        // Timeout with one ack stuck low
        bus.predict_fail = 1'b1; bus.fail_addr = 32'h0000_4000;
        step();
        bus.predict_fail = 1'b0; bus.unit_flush_ack = 4'b0111;
        first_rv = 0;
        rv_cnt = 0;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk_in);
            if (bus.redirect_valid && first_rv == 0) first_rv = k;
            if (bus.redirect_valid) rv_cnt++;
            if (k == 65) chk("timeout.err_before", 32'(bus.timeout_err), 32'd0);
            step();
        end
        chk("timeout.redirect_cycle", 32'(first_rv), 32'd66);
        chk("timeout.redirect_pulses", 32'(rv_cnt), 32'd1);
        @(negedge clk_in);
        chk_outs("timeout_idle", 1'b0, 1'b0, 1'b0, 32'h0000_4000, 1'b0, 1'b1, 16'd5);
        $display("timeout: redirect at T+%0d, pulses=%0d", first_rv, rv_cnt);
        step();
        bus.unit_flush_ack = '0;

        // Asynchronous reset while in WAIT
        bus.predict_fail = 1'b1; bus.fail_addr = 32'h0000_7000;
        step();
        bus.predict_fail = 1'b0;
        step();
        @(negedge clk_in);
        chk("pre_rst.busy", 32'(bus.busy), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0);
        step();
        rst_in = 1'b0;
        bus.predict_fail = 1'b1; bus.fail_addr = 32'h0000_0801;
        step();
        bus.predict_fail = 1'b0;
        @(negedge clk_in);
        chk_outs("post_rst_flush", 1'b1, 1'b1, 1'b0, 32'h0000_0800, 1'b1, 1'b0, 16'd1);
        step();
        bus.unit_flush_ack = 4'hF;
        step();
        bus.unit_flush_ack = '0;
        @(negedge clk_in);
        chk("post_rst.redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("post_rst.redirect_addr", bus.redirect_addr, 32'h0000_0800);
        $display("async reset sequence done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
